// File: rtl/cu_seq.sv
// cu_seq: decode-stage control unit with a multiply/divide sequencer.
// Decodes op/func into D-stage controls, registers them into E, and
// sequences multi-cycle MULT/MULTU (and DIV/DIVU) with HI/LO write-back.
// Optional feature macro: CU_DIV_EN (defined -> DIV/DIVU decoded and
// sequenced with DIV_CYCLES; undefined -> func 1Ah/1Bh decode as illegal).
module cu_seq #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 16,
  parameter int unsigned ALUCTRL_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           op,
  input  logic [5:0]           func,
  input  logic                 stallD,
  input  logic                 flushE,
  output logic                 regwriteD,
  output logic                 mem2regD,
  output logic                 memwriteD,
  output logic                 branchD,
  output logic                 jumpD,
  output logic                 alusrcD,
  output logic                 regdstD,
  output logic                 lwswD,
  output logic [ALUCTRL_W-1:0] alucontrolD,
  output logic                 illegalD,
  output logic                 regwriteE,
  output logic                 mem2regE,
  output logic                 memwriteE,
  output logic                 alusrcE,
  output logic                 regdstE,
  output logic [ALUCTRL_W-1:0] alucontrolE,
  output logic                 md_start,
  output logic [1:0]           md_op,
  output logic                 md_busy,
  output logic                 stall_md,
  output logic                 hilo_we
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;

`ifdef CU_DIV_EN
  localparam int unsigned MAX_N = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
`else
  localparam int unsigned MAX_N = MUL_CYCLES;
`endif
  localparam int unsigned CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_load;
  logic [3:0]       alu;
  logic             md_dec;
  logic [1:0]       md_kind;
  logic             hilo_rd;
  logic             bubble;
  logic             start;

  // Instruction decode into D-stage controls
  always_comb begin
    regwriteD = 1'b0;
    mem2regD  = 1'b0;
    memwriteD = 1'b0;
    branchD   = 1'b0;
    jumpD     = 1'b0;
    alusrcD   = 1'b0;
    regdstD   = 1'b0;
    lwswD     = 1'b0;
    illegalD  = 1'b0;
    alu       = ALU_AND;
    md_dec    = 1'b0;
    md_kind   = 2'b00;
    hilo_rd   = 1'b0;
    case (op)
      6'h00: begin
        regdstD = 1'b1;
        case (func)
          6'h20, 6'h21: begin regwriteD = 1'b1; alu = ALU_ADD;  end
          6'h22, 6'h23: begin regwriteD = 1'b1; alu = ALU_SUB;  end
          6'h24:        begin regwriteD = 1'b1; alu = ALU_AND;  end
          6'h25:        begin regwriteD = 1'b1; alu = ALU_OR;   end
          6'h26:        begin regwriteD = 1'b1; alu = ALU_XOR;  end
          6'h27:        begin regwriteD = 1'b1; alu = ALU_NOR;  end
          6'h2A:        begin regwriteD = 1'b1; alu = ALU_SLT;  end
          6'h2B:        begin regwriteD = 1'b1; alu = ALU_SLTU; end
          6'h10, 6'h12: begin regwriteD = 1'b1; hilo_rd = 1'b1; end
          6'h18:        begin md_dec = 1'b1; md_kind = 2'b00; end
          6'h19:        begin md_dec = 1'b1; md_kind = 2'b01; end
`ifdef CU_DIV_EN
          6'h1A:        begin md_dec = 1'b1; md_kind = 2'b10; end
          6'h1B:        begin md_dec = 1'b1; md_kind = 2'b11; end
`endif
          default:      begin regdstD = 1'b0; illegalD = 1'b1; end
        endcase
      end
      6'h08, 6'h09: begin regwriteD = 1'b1; alusrcD = 1'b1; alu = ALU_ADD; end
      6'h0A:        begin regwriteD = 1'b1; alusrcD = 1'b1; alu = ALU_SLT; end
      6'h0C:        begin regwriteD = 1'b1; alusrcD = 1'b1; alu = ALU_AND; end
      6'h0D:        begin regwriteD = 1'b1; alusrcD = 1'b1; alu = ALU_OR;  end
      6'h23: begin
        regwriteD = 1'b1; mem2regD = 1'b1; alusrcD = 1'b1; lwswD = 1'b1; alu = ALU_ADD;
      end
      6'h2B: begin
        memwriteD = 1'b1; alusrcD = 1'b1; lwswD = 1'b1; alu = ALU_ADD;
      end
      6'h04, 6'h05: begin branchD = 1'b1; alu = ALU_SUB; end
      6'h02:        jumpD = 1'b1;
      6'h03:        begin jumpD = 1'b1; regwriteD = 1'b1; end
      default:      illegalD = 1'b1;
    endcase
  end

  assign alucontrolD = ALUCTRL_W'(alu);

  // Hazard interaction: stall HI/LO consumers and new MD ops while busy
  assign stall_md = md_busy & (md_dec | hilo_rd);
  assign bubble   = stallD | flushE | stall_md;
  assign start    = (state == S_IDLE) & md_dec & ~bubble;

`ifdef CU_DIV_EN
  assign cnt_load = md_kind[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
`else
  logic unused_div_cycles;
  assign unused_div_cycles = ^32'(DIV_CYCLES);
  assign cnt_load = CNT_W'(MUL_CYCLES - 1);
`endif

  // Sequencer state register and start/op capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      md_start <= 1'b0;
      md_op    <= 2'b00;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      md_start <= start;
      if (start) md_op <= md_kind;
    end
  end

  // Sequencer next-state: count down N busy cycles then one DONE cycle
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: if (start) begin
        state_next = S_BUSY;
        cnt_next   = cnt_load;
      end
      S_BUSY: begin
        if (cnt == '0) state_next = S_DONE;
        else           cnt_next   = cnt - CNT_W'(1);
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Sequencer outputs decoded from the state register
  always_comb begin
    md_busy = 1'b0;
    hilo_we = 1'b0;
    case (state)
      S_BUSY:  md_busy = 1'b1;
      S_DONE:  begin md_busy = 1'b1; hilo_we = 1'b1; end
      default: begin md_busy = 1'b0; hilo_we = 1'b0; end
    endcase
  end

  // ID/EX control register; bubbles insert an all-zero bundle
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      regwriteE   <= 1'b0;
      mem2regE    <= 1'b0;
      memwriteE   <= 1'b0;
      alusrcE     <= 1'b0;
      regdstE     <= 1'b0;
      alucontrolE <= '0;
    end else begin
      regwriteE   <= regwriteD;
      mem2regE    <= mem2regD;
      memwriteE   <= memwriteD;
      alusrcE     <= alusrcD;
      regdstE     <= regdstD;
      alucontrolE <= alucontrolD;
    end
  end

endmodule

// File: tb/tb_cu_seq.sv
// tb_cu_seq: table vectors, hand sequences and randomized traffic for cu_seq,
// checked against an instruction-class reference model.
module tb_cu_seq;

  localparam int unsigned MULN = 4;
  localparam int unsigned DIVN = 16;
  localparam int unsigned AW   = 4;
`ifdef CU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  localparam int C_ILL = 0, C_RALU = 1, C_HILO = 2, C_MD = 3, C_IALU = 4,
                 C_LW = 5, C_SW = 6, C_BR = 7, C_J = 8, C_JAL = 9;

  typedef struct packed {
    logic       regwrite, mem2reg, memwrite, branch, jump, alusrc, regdst, lwsw;
    logic [3:0] alu;
    logic       illegal;
  } dctl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] func;
    dctl_t      exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst, stallD, flushE;
  logic [5:0] op, func;
  logic regwriteD, mem2regD, memwriteD, branchD, jumpD, alusrcD, regdstD, lwswD, illegalD;
  logic [AW-1:0] alucontrolD, alucontrolE;
  logic regwriteE, mem2regE, memwriteE, alusrcE, regdstE;
  logic md_start, md_busy, stall_md, hilo_we;
  logic [1:0] md_op;

  always #5 clk = ~clk;

  cu_seq #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN), .ALUCTRL_W(AW)) dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .stallD(stallD), .flushE(flushE),
    .regwriteD(regwriteD), .mem2regD(mem2regD), .memwriteD(memwriteD),
    .branchD(branchD), .jumpD(jumpD), .alusrcD(alusrcD), .regdstD(regdstD),
    .lwswD(lwswD), .alucontrolD(alucontrolD), .illegalD(illegalD),
    .regwriteE(regwriteE), .mem2regE(mem2regE), .memwriteE(memwriteE),
    .alusrcE(alusrcE), .regdstE(regdstE), .alucontrolE(alucontrolE),
    .md_start(md_start), .md_op(md_op), .md_busy(md_busy),
    .stall_md(stall_md), .hilo_we(hilo_we)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: cycles remaining until the sequencer is idle again
  int    rem = 0;
  dctl_t e_exp = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] dut_d();
    return {regwriteD, mem2regD, memwriteD, branchD, jumpD, alusrcD, regdstD, lwswD,
            alucontrolD[3:0], illegalD};
  endfunction

  function automatic logic [8:0] dut_e();
    return {regwriteE, mem2regE, memwriteE, alusrcE, regdstE, alucontrolE[3:0]};
  endfunction

  function automatic logic [8:0] proj_e(input dctl_t d);
    return {d.regwrite, d.mem2reg, d.memwrite, d.alusrc, d.regdst, d.alu};
  endfunction

  // Reference decode: classify the instruction, then derive controls from class rules
  function automatic dctl_t ref_decode(input logic [5:0] o, input logic [5:0] f,
                                       output int cls, output logic [1:0] k);
    dctl_t d;
    logic [3:0] a;
    d = '0; a = 4'h0; cls = C_ILL; k = 2'b00;
    if (o == 6'h00) begin
      case (f)
        6'h20, 6'h21: begin cls = C_RALU; a = 4'b0010; end
        6'h22, 6'h23: begin cls = C_RALU; a = 4'b0110; end
        6'h24: begin cls = C_RALU; a = 4'b0000; end
        6'h25: begin cls = C_RALU; a = 4'b0001; end
        6'h26: begin cls = C_RALU; a = 4'b0011; end
        6'h27: begin cls = C_RALU; a = 4'b0100; end
        6'h2A: begin cls = C_RALU; a = 4'b0111; end
        6'h2B: begin cls = C_RALU; a = 4'b1000; end
        6'h10, 6'h12: cls = C_HILO;
        6'h18: begin cls = C_MD; k = 2'b00; end
        6'h19: begin cls = C_MD; k = 2'b01; end
        6'h1A: if (DIV_EN) begin cls = C_MD; k = 2'b10; end
        6'h1B: if (DIV_EN) begin cls = C_MD; k = 2'b11; end
        default: cls = C_ILL;
      endcase
    end else begin
      case (o)
        6'h08, 6'h09: begin cls = C_IALU; a = 4'b0010; end
        6'h0A: begin cls = C_IALU; a = 4'b0111; end
        6'h0C: begin cls = C_IALU; a = 4'b0000; end
        6'h0D: begin cls = C_IALU; a = 4'b0001; end
        6'h23: begin cls = C_LW; a = 4'b0010; end
        6'h2B: begin cls = C_SW; a = 4'b0010; end
        6'h04, 6'h05: begin cls = C_BR; a = 4'b0110; end
        6'h02: cls = C_J;
        6'h03: cls = C_JAL;
        default: cls = C_ILL;
      endcase
    end
    d.regwrite = (cls == C_RALU) || (cls == C_HILO) || (cls == C_IALU) || (cls == C_LW) || (cls == C_JAL);
    d.regdst   = (cls == C_RALU) || (cls == C_HILO) || (cls == C_MD);
    d.alusrc   = (cls == C_IALU) || (cls == C_LW) || (cls == C_SW);
    d.lwsw     = (cls == C_LW) || (cls == C_SW);
    d.mem2reg  = (cls == C_LW);
    d.memwrite = (cls == C_SW);
    d.branch   = (cls == C_BR);
    d.jump     = (cls == C_J) || (cls == C_JAL);
    d.illegal  = (cls == C_ILL);
    d.alu      = a;
    return d;
  endfunction

  // One clock: drive, check combinational outputs, clock, check registered outputs
  task automatic step(input logic [5:0] o, input logic [5:0] f,
                      input logic sd, input logic fe, input logic r);
    dctl_t d;
    int cls;
    logic [1:0] k;
    logic stall, bubble, start;
    op = o; func = f; stallD = sd; flushE = fe; rst = r;
    #1;
    d = ref_decode(o, f, cls, k);
    stall = (rem > 0) && ((cls == C_MD) || (cls == C_HILO));
    chk("d_ctrl", 32'(dut_d()), 32'(d));
    chk("stall_md", 32'(stall_md), 32'(stall));
    bubble = sd | fe | stall;
    start  = !r && (rem == 0) && (cls == C_MD) && !bubble;
    if (r) begin
      rem = 0;
      e_exp = '0;
    end else begin
      if (rem > 0) rem--;
      if (start) rem = int'(k[1] ? DIVN : MULN) + 1;
      e_exp = bubble ? '0 : d;
    end
    @(posedge clk);
    #1;
    chk("e_ctrl", 32'(dut_e()), 32'(proj_e(e_exp)));
    chk("md_busy", 32'(md_busy), 32'(rem > 0));
    chk("hilo_we", 32'(hilo_we), 32'(rem == 1));
    chk("md_start", 32'(md_start), 32'(start));
    if (start) chk("md_op", 32'(md_op), 32'(k));
  endtask

  vec_t tbl[20];
  logic [5:0] lops[27];
  logic [5:0] lfun[27];

  initial begin
    op = 6'h00; func = 6'h20; stallD = 1'b0; flushE = 1'b0; rst = 1'b1;

    // Reset state
    step(6'h00, 6'h20, 1'b0, 1'b0, 1'b1);
    step(6'h00, 6'h20, 1'b0, 1'b0, 1'b1);
    chk("rst_e", 32'(dut_e()), 32'h0);
    chk("rst_busy", 32'(md_busy), 32'h0);
    chk("rst_hilo", 32'(hilo_we), 32'h0);
    chk("rst_start", 32'(md_start), 32'h0);

    // Fields: regwrite mem2reg memwrite branch jump alusrc regdst lwsw | alu | illegal
    tbl[0]  = '{6'h00, 6'h20, 13'b10000010_0010_0};
    tbl[1]  = '{6'h00, 6'h22, 13'b10000010_0110_0};
    tbl[2]  = '{6'h00, 6'h24, 13'b10000010_0000_0};
    tbl[3]  = '{6'h00, 6'h25, 13'b10000010_0001_0};
    tbl[4]  = '{6'h00, 6'h26, 13'b10000010_0011_0};
    tbl[5]  = '{6'h00, 6'h27, 13'b10000010_0100_0};
    tbl[6]  = '{6'h00, 6'h2A, 13'b10000010_0111_0};
    tbl[7]  = '{6'h00, 6'h2B, 13'b10000010_1000_0};
    tbl[8]  = '{6'h00, 6'h10, 13'b10000010_0000_0};
    tbl[9]  = '{6'h08, 6'h15, 13'b10000100_0010_0};
    tbl[10] = '{6'h0A, 6'h00, 13'b10000100_0111_0};
    tbl[11] = '{6'h0D, 6'h3F, 13'b10000100_0001_0};
    tbl[12] = '{6'h23, 6'h07, 13'b11000101_0010_0};
    tbl[13] = '{6'h2B, 6'h01, 13'b00100101_0010_0};
    tbl[14] = '{6'h04, 6'h00, 13'b00010000_0110_0};
    tbl[15] = '{6'h03, 6'h00, 13'b10001000_0000_0};
    tbl[16] = '{6'h02, 6'h00, 13'b00001000_0000_0};
    tbl[17] = '{6'h3F, 6'h20, 13'b00000000_0000_1};
    tbl[18] = '{6'h00, 6'h3F, 13'b00000000_0000_1};
    tbl[19] = '{6'h00, 6'h1A, DIV_EN ? 13'b00000010_0000_0 : 13'b00000000_0000_1};
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].op, tbl[i].func, 1'b0, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_d", i), 32'(dut_d()), 32'(tbl[i].exp));
      chk($sformatf("tbl%0d_e", i), 32'(dut_e()), 32'(proj_e(tbl[i].exp)));
    end

    // MULT followed by MFLO held in D
    step(6'h00, 6'h20, 1'b0, 1'b0, 1'b1);
    step(6'h00, 6'h18, 1'b0, 1'b0, 1'b0);
    chk("mul_start", 32'(md_start), 32'h1);
    chk("mul_op", 32'(md_op), 32'h0);
    for (int c = 1; c <= 6; c++) begin
      op = 6'h00; func = 6'h12;
      #1;
      chk($sformatf("mflo_stall_c%0d", c), 32'(stall_md), 32'(c <= 5));
      chk($sformatf("mflo_hilo_c%0d", c), 32'(hilo_we), 32'(c == 5));
      step(6'h00, 6'h12, 1'b0, 1'b0, 1'b0);
    end
    chk("mflo_in_e", 32'(dut_e()), 32'(9'b10001_0000));
    chk("mul_idle", 32'(md_busy), 32'h0);

    // MULT under flushE: bubble only, no start
    step(6'h00, 6'h18, 1'b0, 1'b1, 1'b0);
    chk("flush_start", 32'(md_start), 32'h0);
    chk("flush_busy", 32'(md_busy), 32'h0);
    chk("flush_e", 32'(dut_e()), 32'h0);
    step(6'h00, 6'h20, 1'b0, 1'b0, 1'b0);
    chk("flush_busy2", 32'(md_busy), 32'h0);

`ifdef CU_DIV_EN
    // DIVU aborted by reset in BUSY cycle 8
    step(6'h00, 6'h1B, 1'b0, 1'b0, 1'b0);
    chk("div_start", 32'(md_start), 32'h1);
    chk("div_op", 32'(md_op), 32'h3);
    for (int c = 1; c <= 7; c++) begin
      step(6'h00, 6'h20, (c == 3), 1'b0, 1'b0);
      chk($sformatf("div_busy_c%0d", c + 1), 32'(md_busy), 32'h1);
    end
    step(6'h00, 6'h20, 1'b0, 1'b0, 1'b1);
    chk("div_abort_busy", 32'(md_busy), 32'h0);
    chk("div_abort_e", 32'(dut_e()), 32'h0);
    for (int c = 0; c < 20; c++) begin
      step(6'h00, 6'h20, 1'b0, 1'b0, 1'b0);
      chk("div_no_hilo", 32'(hilo_we), 32'h0);
    end
`else
    // DIV encoding without divider support is illegal
    step(6'h00, 6'h1A, 1'b0, 1'b0, 1'b0);
    chk("nodiv_illegal", 32'(illegalD), 32'h1);
    chk("nodiv_start", 32'(md_start), 32'h0);
    chk("nodiv_busy", 32'(md_busy), 32'h0);
    chk("nodiv_e", 32'(dut_e()), 32'h0);
`endif

    // Randomized traffic against the reference model
    lops = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
             6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C,
             6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
    lfun = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
             6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h00, 6'h00, 6'h00, 6'h00,
             6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    for (int n = 0; n < 3000; n++) begin
      int sel;
      logic [5:0] o, f;
      sel = int'($urandom_range(0, 31));
      if (sel < 27) begin
        o = lops[sel];
        f = (o == 6'h00) ? lfun[sel] : 6'($urandom);
      end else begin
        o = 6'($urandom);
        f = 6'($urandom);
      end
      step(o, f, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 149) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cu_seq.md
# cu_seq

Parametrised decode-stage control unit for the MiniSys-1A five-stage pipeline, successor to the purely combinational decoder. Decodes op/func into the D-stage control bundle and registers it into the E stage. Adds a sequencer for multi-cycle MULT/MULTU/DIV/DIVU that stalls dependent instructions and pulses the HI/LO write on completion. Sits between the IF/ID register and the ID/EX datapath; the stall and bubble outputs feed the hazard unit.

## Interface
- MUL_CYCLES, 4, execute cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 16, execute cycles for DIV/DIVU (≥1)
- ALUCTRL_W, 4, width of alucontrol (≥4)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- op  in  6  instruction[31:26]
- func  in  6  instruction[5:0]
- stallD  in  1  external D-stage stall from hazard unit
- flushE  in  1  external E-stage flush
- regwriteD, mem2regD, memwriteD, branchD, jumpD, alusrcD, regdstD, lwswD  out  1 each  combinational D-stage controls
- alucontrolD  out  ALUCTRL_W  combinational ALU operation
- illegalD  out  1  unrecognised op/func
- regwriteE, mem2regE, memwriteE, alusrcE, regdstE  out  1 each  registered E-stage controls
- alucontrolE  out  ALUCTRL_W  registered ALU operation
- md_start  out  1  one-cycle pulse, multiply/divide accepted
- md_op  out  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; valid with md_start
- md_busy  out  1  sequencer not IDLE
- stall_md  out  1  stall request to hazard unit
- hilo_we  out  1  one-cycle HI/LO write strobe

## Operation
- Decoded set: R-type (op=0) ADD 20h, ADDU 21h, SUB 22h, SUBU 23h, AND 24h, OR 25h, XOR 26h, NOR 27h, SLT 2Ah, SLTU 2Bh, MFHI 10h, MFLO 12h, MULT 18h, MULTU 19h, DIV 1Ah, DIVU 1Bh; I/J-type ADDI 08h, ADDIU 09h, SLTI 0Ah, ANDI 0Ch, ORI 0Dh, LW 23h, SW 2Bh, BEQ 04h, BNE 05h, J 02h, JAL 03h.
- ALU codes: AND 0000, OR 0001, ADD/ADDU/ADDI/ADDIU/LW/SW 0010, XOR 0011, NOR 0100, SUB/SUBU/BEQ/BNE 0110, SLT/SLTI 0111, SLTU 1000; upper bits zero.
- regdstD=1 for R-type; alusrcD=1 for I-type ALU, LW, SW; lwswD=1 for LW/SW; mem2regD=1 LW only; memwriteD=1 SW only; branchD for BEQ/BNE; jumpD for J/JAL; regwriteD for R-type ALU, MFHI, MFLO, I-type ALU, LW, JAL; MULT/DIV family: regwriteD=0.
- Unrecognised encoding: illegalD=1, all other D controls 0.
- stall_md = md_busy AND decoded instruction ∈ {MULT, MULTU, DIV, DIVU, MFHI, MFLO}.
- Bubble = stallD OR flushE OR stall_md; on bubble, E registers load all-zero.
- Sequencer FSM: IDLE → BUSY when MD op decoded and no bubble (md_start=1, counter ← N−1, N by op). BUSY: counter decrements; at counter=0 → DONE. DONE: hilo_we=1, → IDLE.
- MD op never starts while md_busy (it is stalled instead).

## Timing
- D outputs: combinational, zero latency.
- E outputs: registered, one cycle after D.
- MD op accepted at edge t: BUSY for cycles t+1..t+N, hilo_we high in cycle t+N+1 only, IDLE from t+N+2; a waiting MFHI/MFLO or MD op proceeds from cycle t+N+2.
- N=1: one BUSY cycle, then DONE.
- Reset: all E outputs, md_start, md_busy, stall_md-state, hilo_we = 0; FSM IDLE, counter 0. rst in BUSY/DONE aborts without hilo_we.
- Simultaneous stallD/flushE with MD decode in IDLE: no start, bubble only.
- stallD while BUSY: counter continues.

## Configuration
- CU_DIV_EN defined: DIV/DIVU decoded and sequenced with DIV_CYCLES.
- CU_DIV_EN undefined: func 1Ah/1Bh decode as illegal (illegalD=1, no md_start, no stall); DIV_CYCLES unused.

## Test plan
- op=00h func=20h → regwriteD=1, regdstD=1, alucontrolD=0010, illegalD=0; next cycle regwriteE=1, alucontrolE=0010.
- op=23h (LW) → alusrcD=1, mem2regD=1, lwswD=1, regwriteD=1; op=2Bh (SW) → memwriteD=1, regwriteD=0.
- MULT with MUL_CYCLES=4, then MFLO held in D → md_start at edge 0, stall_md high 5 cycles, hilo_we in cycle 5, MFLO enters E in cycle 6.
- DIVU with DIV_CYCLES=16 and rst asserted in BUSY cycle 8 → FSM IDLE next cycle, hilo_we never asserted, all E outputs 0.
- MULT decoded with flushE=1 → md_start=0, md_busy stays 0, E controls 0.
- CU_DIV_EN undefined, op=00h func=1Ah → illegalD=1, md_start=0, all controls 0.
